hamming_rx_buffer: RTL
======================

Name: hamming_rx_buffer

Overview:
Clocked receive stage that accepts Hamming-encoded codewords (IP_BIT data bits plus 4 parity bits) under a valid/ready handshake. It computes the syndrome and corrects any single-bit error, then queues the corrected data in a FIFO. The downstream consumer (matrix/compute datapath) drains the FIFO through its own valid/ready handshake. The block also keeps a saturating count of corrected words.

Parameters:
IP_BIT, 11, data bits per codeword; codeword width is IP_BIT+4; legal range 5..11.
DEPTH, 4, FIFO entries; power of two, range 2..16.
CNT_W, 8, width of the corrected-error counter.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_code is valid this cycle
in_code  input  IP_BIT+4  encoded codeword
in_ready  output  1  block can accept a word this cycle
out_valid  output  1  FIFO head is valid
out_ready  input  1  consumer takes the head this cycle
out_data  output  IP_BIT  corrected data at the FIFO head
out_err  output  1  FIFO head word had a nonzero syndrome
err_cnt  output  CNT_W  count of accepted words with a nonzero syndrome

Behaviour:
- Reset (async assert, sync release) state:
  - FIFO empty.
  - in_ready=1.
  - out_valid=0, out_data=0, out_err=0.
  - err_cnt=0.
  - Reset mid-transfer discards all queued words.
- Codeword bit mapping:
  - Position p (1..IP_BIT+4) is in_code[IP_BIT+4-p], so the MSB is position 1.
  - Parity bits sit at positions 1, 2, 4 and 8.
  - Data bits sit at the remaining positions in ascending order; the lowest such position (3) is out_data MSB.
- Decode (combinational, on in_code):
  - syndrome = 4-bit XOR of p over every position p whose bit is 1.
  - syndrome=0: no correction; err=0.
  - 1 <= syndrome <= IP_BIT+4: invert the bit at position syndrome, then extract data; err=1.
  - syndrome > IP_BIT+4 (possible only when IP_BIT<11): no flip; err=1.
  - Corrected data and err are written to the FIFO together.
- Input handshake:
  - Push when in_valid && in_ready.
  - in_ready = !full, driven from registered occupancy, with no combinational path from out_ready.
  - When full, in_ready=0; a word on in_code stays unaccepted and the source must hold it.
- Output handshake:
  - out_valid = !empty; out_data and out_err show the FIFO head.
  - Pop when out_valid && out_ready.
  - out_data/out_err hold steady while out_valid && !out_ready.
- Latency: a word pushed at edge N is visible at the head after edge N (cycle N+1) if the FIFO was empty. No combinational input-to-output path.
- Simultaneous push and pop:
  - Not full and not empty: both happen; occupancy unchanged.
  - Empty: push only; the word appears next cycle.
  - Full: pop only, because in_ready=0; in_ready rises the next cycle.
- Pointers: read and write pointers of log2(DEPTH) bits wrap modulo DEPTH. Occupancy counter is 0..DEPTH; full = (count==DEPTH), empty = (count==0).
- err_cnt:
  - Increments on each push whose err=1.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Cleared only by reset.
- Data is not altered when err=1 and syndrome is out of range; it passes through uncorrected.
- Double-bit errors are not detected. They produce a miscorrection, which is the expected behaviour.

Test Plan:
- Clean word, IP_BIT=11: push in_code=15'h6881 with out_ready=1 -> next cycle out_valid=1, out_data=11'h001, out_err=0, err_cnt=0. Push 15'h0000 -> out_data=11'h000, out_err=0.
- Data-bit error: push 15'h6880 (position 15 flipped) -> out_data=11'h001, out_err=1, err_cnt=1.
- Parity-bit error: push 15'h6081 (position 4 flipped) -> out_data=11'h001, out_err=1, err_cnt=2 (continuing from the previous scenario).
- Backpressure and full, DEPTH=4: hold out_ready=0, push 5 words of distinct clean data 1..5.
  - in_ready drops after the 4th push; the 5th word waits.
  - Raise out_ready -> outputs 1,2,3,4 then 5 in order, no loss or duplication.
  - in_ready returns 1 the cycle after the first pop.
- Simultaneous push/pop at occupancy 2: out_valid, out_ready and in_valid all high for 10 cycles -> occupancy stays 2 and order is preserved. Wrap-around of both pointers is exercised.
- Saturation and reset, CNT_W=2: push 5 erroneous words -> err_cnt=3 and holds. Assert rst_n=0 mid-stream with the FIFO non-empty -> out_valid=0, err_cnt=0, in_ready=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hamming_rx_buffer.sv
`timescale 1ns/1ps
// Hamming receive stage: corrects single-bit errors in incoming codewords and
// queues the corrected data plus an error flag in a small FIFO for the consumer.
module hamming_rx_buffer #(
  parameter int IP_BIT = 11,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [IP_BIT+3:0] in_code,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IP_BIT-1:0] out_data,
  output logic              out_err,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int CW = IP_BIT + 4;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Position p lives at code[CW-p]; the syndrome is the XOR of all set positions.
  function automatic logic [3:0] calc_syndrome(input logic [CW-1:0] code);
    logic [3:0] s;
    s = '0;
    for (int p = 1; p <= CW; p++)
      if (code[CW-p]) s = s ^ 4'(p);
    return s;
  endfunction

  // Out-of-range syndromes (short codes only) leave the word untouched.
  function automatic logic [IP_BIT-1:0] correct_data(input logic [CW-1:0] code,
                                                     input logic [3:0]    s);
    logic [CW-1:0]     fixed;
    logic [IP_BIT-1:0] d;
    int                k;
    fixed = code;
    if (s != 4'd0 && int'(s) <= CW)
      fixed[CW-int'(s)] = ~fixed[CW-int'(s)];
    d = '0;
    k = IP_BIT - 1;
    for (int p = 1; p <= CW; p++) begin
      if (p != 1 && p != 2 && p != 4 && p != 8) begin
        d[k] = fixed[CW-p];
        k--;
      end
    end
    return d;
  endfunction

  logic [3:0]        syn;
  logic [IP_BIT-1:0] dec_data;
  logic              dec_err;

  always_comb begin
    syn      = calc_syndrome(in_code);
    dec_data = correct_data(in_code, syn);
    dec_err  = (syn != 4'd0);
  end

  logic [IP_BIT:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign push  = in_valid && !full;
  assign pop   = !empty && out_ready;

  // Storage carries data only; validity comes from the occupancy counter.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {dec_err, dec_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (push && dec_err && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign {out_err, out_data} = empty ? '0 : mem[rd_ptr];

endmodule
